avalon_dram_req_arbiter: RTL and testbench

//  Shares one Avalon DRAM controller command port among NUM_REQ NoC-side requesters.

---
 rtl/avalon_dram_req_arbiter_if.sv | 38 +++
 rtl/avalon_dram_req_arbiter.sv | 174 +++++++++++++++++
 tb/tb_avalon_dram_req_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_dram_req_arbiter_if.sv
// Bus bundle between NoC-side DRAM request engines, the arbiter and the Avalon memory port.
// slave = arbiter view, master = requester/memory environment view.
interface avalon_dram_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 512
);
  logic [NUM_REQ-1:0]        req_read_en;
  logic [NUM_REQ-1:0]        req_write_en;
  logic [NUM_REQ-1:0]        req_wr_last;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wr_data;
  logic [NUM_REQ-1:0]        req_rdy;
  logic                      mem_read_en;
  logic                      mem_write_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wr_data;
  logic                      mem_rdy;
  logic                      mem_rd_data_val;
  logic [DATA_W-1:0]         mem_rd_data;
  logic [NUM_REQ-1:0]        req_rd_data_val;
  logic [DATA_W-1:0]         req_rd_data;
  logic                      arb_err;

  modport slave (
    input  req_read_en, req_write_en, req_wr_last, req_addr, req_wr_data,
    input  mem_rdy, mem_rd_data_val, mem_rd_data,
    output req_rdy, mem_read_en, mem_write_en, mem_addr, mem_wr_data,
    output req_rd_data_val, req_rd_data, arb_err
  );

  modport master (
    output req_read_en, req_write_en, req_wr_last, req_addr, req_wr_data,
    output mem_rdy, mem_rd_data_val, mem_rd_data,
    input  req_rdy, mem_read_en, mem_write_en, mem_addr, mem_wr_data,
    input  req_rd_data_val, req_rd_data, arb_err
  );
endinterface

// File: rtl/avalon_dram_req_arbiter.sv
// Round-robin arbiter sharing one Avalon DRAM command port among NUM_REQ requesters.
// Write bursts hold the grant until wr_last; read returns are steered back through an ID FIFO.
module avalon_dram_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 512,
  parameter int MAX_OUT = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  avalon_dram_req_arbiter_if.slave bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    WR_BURST = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   lock_q, lock_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             err_q;
  logic [IDW-1:0]   fifo_q [MAX_OUT];

  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];

  logic               fifo_full, fifo_empty, push, pop;
  logic [NUM_REQ-1:0] elig;
  logic               gnt_vld, gnt_is_rd;
  logic [IDW-1:0]     gnt_id;
  logic [IDW:0]       scan_sum;
  logic [IDW-1:0]     scan_id;
  logic               rd_en, wr_en, sel_vld;
  logic [IDW-1:0]     sel;
  logic [NUM_REQ-1:0] rdy, rd_val;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = bus.req_wr_data[i*DATA_W +: DATA_W];
  end

  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] id);
    if (id == IDW'(NUM_REQ - 1)) return '0;
    return id + 1'b1;
  endfunction

  assign fifo_full  = (cnt_q == (AW+1)'(MAX_OUT));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = bus.mem_rd_data_val && !fifo_empty;

  // A read can only be presented while the return path has room to record its issuer.
  assign elig = bus.req_write_en | (bus.req_read_en & {NUM_REQ{!fifo_full}});

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    scan_sum = '0;
    scan_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NUM_REQ)) scan_sum = scan_sum - (IDW+1)'(NUM_REQ);
      scan_id = scan_sum[IDW-1:0];
      if (!gnt_vld && elig[scan_id]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan_id;
      end
    end
  end

  assign gnt_is_rd = bus.req_read_en[gnt_id] && !fifo_full;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    push    = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    sel_vld = 1'b0;
    sel     = gnt_id;
    rdy     = '0;
    unique case (state_q)
      ARB: begin
        sel_vld = gnt_vld;
        if (gnt_vld) begin
          rdy[gnt_id] = bus.mem_rdy;
          if (gnt_is_rd) begin
            rd_en = 1'b1;
            if (bus.mem_rdy) begin
              push = 1'b1;
              rr_d = rr_next(gnt_id);
            end
          end else begin
            wr_en = 1'b1;
            if (bus.mem_rdy) begin
              if (bus.req_wr_last[gnt_id]) begin
                rr_d = rr_next(gnt_id);
              end else begin
                lock_d  = gnt_id;
                state_d = WR_BURST;
              end
            end
          end
        end
      end
      WR_BURST: begin
        sel         = lock_q;
        sel_vld     = 1'b1;
        wr_en       = bus.req_write_en[lock_q];
        rdy[lock_q] = bus.mem_rdy;
        if (wr_en && bus.mem_rdy && bus.req_wr_last[lock_q]) begin
          rr_d    = rr_next(lock_q);
          state_d = ARB;
        end
      end
      default: begin
        // Corrupted state register: poison every output so simulation flags it.
        state_d = ARB;
        rd_en   = 1'bx;
        wr_en   = 1'bx;
        sel_vld = 1'bx;
        sel     = 'x;
        rdy     = 'x;
      end
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (pop) rd_val[fifo_q[rd_ptr_q]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      rr_q     <= '0;
      lock_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      lock_q   <= lock_d;
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (bus.mem_rd_data_val && fifo_empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= gnt_id;
  end

  // Outputs are forced quiet while reset is held, independent of requester activity.
  assign bus.mem_read_en     = rst_n & rd_en;
  assign bus.mem_write_en    = rst_n & wr_en;
  assign bus.req_rdy         = rst_n ? rdy : '0;
  assign bus.mem_addr        = (rst_n && sel_vld) ? addr_a[sel] : '0;
  assign bus.mem_wr_data     = (rst_n && sel_vld) ? data_a[sel] : '0;
  assign bus.req_rd_data_val = rst_n ? rd_val : '0;
  assign bus.req_rd_data     = rst_n ? bus.mem_rd_data : '0;
  assign bus.arb_err         = err_q;

endmodule

// File: tb/tb_avalon_dram_req_arbiter.sv
// Directed bench for avalon_dram_req_arbiter: round robin, burst lock, backpressure,
// ID FIFO full/return, empty-return error and mid-activity reset.
module tb_avalon_dram_req_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 8;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] wd0;

  always #5 clk = ~clk;

  avalon_dram_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  avalon_dram_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_re"},   64'(bus.mem_read_en), 64'd0);
    chk({tag, "_we"},   64'(bus.mem_write_en), 64'd0);
    chk({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_wd"},   64'(bus.mem_wr_data), 64'd0);
    chk({tag, "_rdy"},  64'(bus.req_rdy), 64'd0);
    chk({tag, "_rval"}, 64'(bus.req_rd_data_val), 64'd0);
    chk({tag, "_rdat"}, 64'(bus.req_rd_data), 64'd0);
    chk({tag, "_err"},  64'(bus.arb_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                = 1'b0;
    bus.req_read_en      = 2'b11;
    bus.req_write_en     = 2'b00;
    bus.req_wr_last      = 2'b00;
    bus.req_addr         = {A1, A0};
    bus.req_wr_data      = {32'h0000_00B1, 32'h0000_00A0};
    bus.mem_rdy          = 1'b1;
    bus.mem_rd_data_val  = 1'b1;
    bus.mem_rd_data      = 32'h5;
    #3;
    chk_quiet("rst0");
    tick();
    tick();
    rst_n               = 1'b1;
    bus.req_read_en     = 2'b00;
    bus.mem_rd_data_val = 1'b0;

    // Round robin reads, then returns in issue order
    bus.req_read_en = 2'b11;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_re",   64'(bus.mem_read_en), 64'd1);
      chk("rr_addr", 64'(bus.mem_addr), (k % 2 == 1) ? 64'(A1) : 64'(A0));
      chk("rr_rdy",  64'(bus.req_rdy), (k % 2 == 1) ? 64'd2 : 64'd1);
      tick();
    end
    bus.req_read_en     = 2'b00;
    bus.mem_rd_data_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rd_data = 32'hD0 + 32'(k);
      settle();
      chk("rr_rval", 64'(bus.req_rd_data_val), (k % 2 == 1) ? 64'd2 : 64'd1);
      chk("rr_rdat", 64'(bus.req_rd_data), 64'hD0 + 64'(k));
      tick();
    end
    bus.mem_rd_data_val = 1'b0;

    // Burst lock: req0 4-beat write while req1 read waits
    bus.req_write_en = 2'b01;
    bus.req_read_en  = 2'b10;
    for (int b = 0; b < 4; b++) begin
      wd0 = 32'hA0 + 32'(b);
      bus.req_wr_data = {32'h0000_00B1, wd0};
      bus.req_wr_last = (b == 3) ? 2'b01 : 2'b00;
      settle();
      chk("bl_we",   64'(bus.mem_write_en), 64'd1);
      chk("bl_re",   64'(bus.mem_read_en), 64'd0);
      chk("bl_rdy",  64'(bus.req_rdy), 64'd1);
      chk("bl_data", 64'(bus.mem_wr_data), 64'hA0 + 64'(b));
      tick();
    end
    bus.req_write_en = 2'b00;
    bus.req_wr_last  = 2'b00;
    settle();
    chk("bl_g1_re",   64'(bus.mem_read_en), 64'd1);
    chk("bl_g1_addr", 64'(bus.mem_addr), 64'(A1));
    chk("bl_g1_rdy",  64'(bus.req_rdy), 64'd2);
    tick();
    bus.req_read_en     = 2'b00;
    bus.mem_rd_data_val = 1'b1;
    bus.mem_rd_data     = 32'hE1;
    settle();
    chk("bl_rval", 64'(bus.req_rd_data_val), 64'd2);
    tick();
    bus.mem_rd_data_val = 1'b0;

    // Backpressure inside a burst; req1 write competes
    bus.req_write_en = 2'b11;
    bus.req_wr_last  = 2'b10;
    bus.req_wr_data  = {32'h0000_00B1, 32'h0000_00C0};
    settle();
    chk("bp_b1_rdy", 64'(bus.req_rdy), 64'd1);
    chk("bp_b1_adr", 64'(bus.mem_addr), 64'(A0));
    tick();
    bus.mem_rdy     = 1'b0;
    bus.req_wr_last = 2'b11;
    bus.req_wr_data = {32'h0000_00B1, 32'h0000_00C1};
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("bp_we",   64'(bus.mem_write_en), 64'd1);
      chk("bp_rdy",  64'(bus.req_rdy), 64'd0);
      chk("bp_addr", 64'(bus.mem_addr), 64'(A0));
      chk("bp_data", 64'(bus.mem_wr_data), 64'hC1);
      tick();
    end
    bus.mem_rdy = 1'b1;
    settle();
    chk("bp_b2_rdy",  64'(bus.req_rdy), 64'd1);
    chk("bp_b2_data", 64'(bus.mem_wr_data), 64'hC1);
    tick();
    bus.req_write_en = 2'b10;
    settle();
    chk("bp_g1_addr", 64'(bus.mem_addr), 64'(A1));
    chk("bp_g1_rdy",  64'(bus.req_rdy), 64'd2);
    tick();
    bus.req_write_en = 2'b00;
    bus.req_wr_last  = 2'b00;

    // ID FIFO full: 8 reads outstanding, 9th stalls, writes still pass
    bus.req_read_en = 2'b01;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("fl_rdy", 64'(bus.req_rdy), 64'd1);
      tick();
    end
    settle();
    chk("fl_st_rdy", 64'(bus.req_rdy), 64'd0);
    chk("fl_st_re",  64'(bus.mem_read_en), 64'd0);
    chk("fl_st_we",  64'(bus.mem_write_en), 64'd0);
    bus.req_write_en = 2'b10;
    bus.req_wr_last  = 2'b10;
    settle();
    chk("fl_w_we",   64'(bus.mem_write_en), 64'd1);
    chk("fl_w_rdy",  64'(bus.req_rdy), 64'd2);
    chk("fl_w_addr", 64'(bus.mem_addr), 64'(A1));
    tick();
    bus.req_write_en    = 2'b00;
    bus.req_wr_last     = 2'b00;
    bus.mem_rd_data_val = 1'b1;
    bus.mem_rd_data     = 32'hF0;
    settle();
    chk("fl_pop_rval", 64'(bus.req_rd_data_val), 64'd1);
    chk("fl_pop_rdy",  64'(bus.req_rdy), 64'd0);
    tick();
    bus.mem_rd_data_val = 1'b0;
    settle();
    chk("fl_re_rdy", 64'(bus.req_rdy), 64'd1);
    chk("fl_re_re",  64'(bus.mem_read_en), 64'd1);
    tick();
    bus.req_read_en     = 2'b00;
    bus.mem_rd_data_val = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("fl_drain", 64'(bus.req_rd_data_val), 64'd1);
      tick();
    end
    bus.mem_rd_data_val = 1'b0;

    // Return with empty ID FIFO
    settle();
    chk("er_pre", 64'(bus.arb_err), 64'd0);
    bus.mem_rd_data_val = 1'b1;
    settle();
    chk("er_rval", 64'(bus.req_rd_data_val), 64'd0);
    tick();
    bus.mem_rd_data_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("er_sticky", 64'(bus.arb_err), 64'd1);
      tick();
    end

    // Reset mid-burst with a read in flight
    bus.req_read_en = 2'b10;
    settle();
    chk("mr_rd_rdy", 64'(bus.req_rdy), 64'd2);
    tick();
    bus.req_read_en  = 2'b00;
    bus.req_write_en = 2'b01;
    bus.req_wr_last  = 2'b00;
    settle();
    chk("mr_wr_rdy", 64'(bus.req_rdy), 64'd1);
    tick();
    bus.req_read_en     = 2'b10;
    bus.mem_rd_data_val = 1'b1;
    rst_n               = 1'b0;
    settle();
    chk_quiet("mr_rst");
    tick();
    rst_n               = 1'b1;
    bus.req_write_en    = 2'b00;
    bus.req_read_en     = 2'b11;
    bus.mem_rd_data_val = 1'b0;
    settle();
    chk("mr_g0_re",   64'(bus.mem_read_en), 64'd1);
    chk("mr_g0_addr", 64'(bus.mem_addr), 64'(A0));
    chk("mr_g0_rdy",  64'(bus.req_rdy), 64'd1);
    tick();
    bus.req_read_en     = 2'b00;
    bus.mem_rd_data_val = 1'b1;
    settle();
    chk("mr_flush_rval", 64'(bus.req_rd_data_val), 64'd1);
    chk("mr_err",        64'(bus.arb_err), 64'd0);
    tick();
    bus.mem_rd_data_val = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
